// File: rtl/flag_write_arbiter.sv
// ---------------------------------------------------------------------------
// flag_write_arbiter
//
// Round-robin write controller for a bank of enable-gated flag flip-flops.
// NREQ requesters each want to write one value into one addressed flag; at
// most one write is issued per cycle as a one-hot ff_en plus a shared ff_d,
// both wired straight into the flag bank.
//
// Optional feature (macro FLAG_ARB_SWEEP_EN): a bulk clear that walks a
// single enable across every flag with ff_d=0, one flag per cycle.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   NFLAG  number of flag flip-flops driven
//   AW     flag address width, 2**AW >= NFLAG
//
// Ports
//   clk          clock, all state updates on the rising edge
//   clr          asynchronous active-low reset
//   req          per-requester write request (level)
//   req_addr     flag address, requester i at [i*AW +: AW]
//   req_val      value to write, requester i at bit i
//   sweep_start  bulk-clear trigger pulse (FLAG_ARB_SWEEP_EN only)
//   gnt          one-hot grant pulse, one cycle
//   ff_en        one-hot enable to the flag bank
//   ff_d         data to the flag bank
//   busy         high while a sweep is in progress (constant 0 without macro)
//   dbg_state    current FSM state (0 = IDLE, 1 = SWEEP) for checkers
//
// Handshake: req[i] with req_addr/req_val is a level request held stable
// until the requester samples gnt[i]=1; that cycle is the transfer. The
// requester may keep req[i] high for another write, which cannot be granted
// before the cycle after next because the current grant masks it.
// ---------------------------------------------------------------------------
module flag_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int AW    = 3
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*AW-1:0]  req_addr,
   input  logic [NREQ-1:0]     req_val,
`ifdef FLAG_ARB_SWEEP_EN
   input  logic                sweep_start,
`endif
   output logic [NREQ-1:0]     gnt,
   output logic [NFLAG-1:0]    ff_en,
   output logic                ff_d,
   output logic                busy,
   output logic                dbg_state
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Registered state and outputs
   // ------------------------------------------------------------------------
   state_t            state, state_nxt;
   logic [PW-1:0]     ptr, ptr_nxt;
   logic [NREQ-1:0]   gnt_nxt;
   logic [NFLAG-1:0]  ff_en_nxt;
   logic              ff_d_nxt;
   logic              busy_nxt;

`ifdef FLAG_ARB_SWEEP_EN
   localparam int CW = (NFLAG > 1) ? $clog2(NFLAG) : 1;
   logic [CW-1:0]     cnt, cnt_nxt;
`endif

   // ------------------------------------------------------------------------
   // Request unpacking and round-robin search
   // ------------------------------------------------------------------------
   logic [AW-1:0]     addr_arr [NREQ];
   logic [NREQ-1:0]   elig;
   logic              win_found;
   logic [PW-1:0]     win_idx;
   logic [AW-1:0]     win_addr;
   logic              win_in_range;
   logic              arb_ok;

   always_comb begin : unpack_addr
      for (int i = 0; i < NREQ; i++) begin
         addr_arr[i] = req_addr[i*AW +: AW];
      end
   end

   // A requester granted in the current cycle is masked, so a held request
   // cannot win at this cycle's closing edge (single-requester rate = 1/2).
   assign elig = req & ~gnt;

   // Search starts at ptr and wraps modulo NREQ; first eligible index wins.
   always_comb begin : rr_search
      int            idx_i;
      logic [PW-1:0] idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx_i     = 0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_i = (int'(ptr) + k) % NREQ;
         idx   = PW'(idx_i);
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   assign win_addr     = addr_arr[win_idx];
   // Addresses beyond the bank still get a grant; only the write is dropped.
   assign win_in_range = (int'(win_addr) < NFLAG);

   // ------------------------------------------------------------------------
   // Next-state / next-output logic
   // ------------------------------------------------------------------------
   always_comb begin : next_logic
      state_nxt = state;
      ptr_nxt   = ptr;
      gnt_nxt   = '0;
      ff_en_nxt = '0;
      ff_d_nxt  = ff_d;     // data holds when nothing is written
      busy_nxt  = 1'b0;
      arb_ok    = 1'b0;
`ifdef FLAG_ARB_SWEEP_EN
      cnt_nxt   = cnt;
      if (state == SWEEP) begin
         // cnt is the flag being cleared in the current cycle.
         if (cnt == CW'(NFLAG-1)) begin
            // Last sweep cycle ends here; arbitration resumes at this same
            // edge so busy falls together with the first possible grant.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            arb_ok    = 1'b1;
         end else begin
            cnt_nxt   = cnt + 1'b1;
            ff_en_nxt = NFLAG'(1) << (cnt + 1'b1);
            ff_d_nxt  = 1'b0;
            busy_nxt  = 1'b1;
         end
      end else if (sweep_start) begin
         // Sweep wins over requests at this edge; pending requests wait.
         state_nxt = SWEEP;
         cnt_nxt   = '0;
         ff_en_nxt = NFLAG'(1);
         ff_d_nxt  = 1'b0;
         busy_nxt  = 1'b1;
      end else begin
         arb_ok = 1'b1;
      end
`else
      arb_ok = 1'b1;
`endif
      if (arb_ok && win_found) begin
         gnt_nxt  = NREQ'(1) << win_idx;
         ff_d_nxt = req_val[win_idx];
         if (win_in_range) begin
            ff_en_nxt = NFLAG'(1) << win_addr;
         end
         ptr_nxt = (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         ptr   <= '0;
         gnt   <= '0;
         ff_en <= '0;
         ff_d  <= 1'b0;
         busy  <= 1'b0;
`ifdef FLAG_ARB_SWEEP_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         gnt   <= gnt_nxt;
         ff_en <= ff_en_nxt;
         ff_d  <= ff_d_nxt;
         busy  <= busy_nxt;
`ifdef FLAG_ARB_SWEEP_EN
         cnt   <= cnt_nxt;
`endif
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_flag_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flag_write_arbiter
//
// Two instances share the request inputs: dut8 (NFLAG=8, full bank) and
// dut6 (NFLAG=6, so address 6/7 are out of range). A behavioural model per
// instance predicts outputs from the round-robin rules; a compare process
// checks both every negative edge. Directed checks pin literal values.
// ---------------------------------------------------------------------------
module tb_flag_write_arbiter;

   // ----------------------------------------------------------------------
   // Clock / reset
   // ----------------------------------------------------------------------
   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   // ----------------------------------------------------------------------
   // DUT signals
   // ----------------------------------------------------------------------
   logic [3:0]  req;
   logic [11:0] req_addr;
   logic [3:0]  req_val;
   logic        sweep_start;

   logic [3:0]  gnt8, gnt6;
   logic [7:0]  ff_en8;
   logic [5:0]  ff_en6;
   logic        ff_d8, ff_d6, busy8, busy6, dbg8, dbg6;

   flag_write_arbiter #(.NREQ(4), .NFLAG(8), .AW(3)) dut8 (
      .clk(clk), .clr(clr), .req(req), .req_addr(req_addr), .req_val(req_val),
`ifdef FLAG_ARB_SWEEP_EN
      .sweep_start(sweep_start),
`endif
      .gnt(gnt8), .ff_en(ff_en8), .ff_d(ff_d8), .busy(busy8), .dbg_state(dbg8)
   );

   flag_write_arbiter #(.NREQ(4), .NFLAG(6), .AW(3)) dut6 (
      .clk(clk), .clr(clr), .req(req), .req_addr(req_addr), .req_val(req_val),
`ifdef FLAG_ARB_SWEEP_EN
      .sweep_start(1'b0),
`endif
      .gnt(gnt6), .ff_en(ff_en6), .ff_d(ff_d6), .busy(busy6), .dbg_state(dbg6)
   );

   // Flag bank driven by dut8: plain enable-gated D flops.
   logic [7:0] q8;
   always @(posedge clk or negedge clr) begin
      if (!clr) q8 <= 8'h00;
      else      q8 <= (q8 & ~ff_en8) | (ff_d8 ? ff_en8 : 8'h00);
   end

   // ----------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ----------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ----------------------------------------------------------------------
   // Behavioural model (index 0 -> dut8, index 1 -> dut6)
   //   m_swk = -1 when not sweeping, otherwise the flag cleared this cycle.
   // ----------------------------------------------------------------------
   logic [3:0] e_gnt  [2];
   logic [7:0] e_en   [2];
   logic       e_d    [2];
   logic       e_busy [2];
   int         m_ptr  [2];
   int         m_swk  [2];

   task automatic model_reset(input int m);
      e_gnt[m] = 4'h0; e_en[m] = 8'h00; e_d[m] = 1'b0; e_busy[m] = 1'b0;
      m_ptr[m] = 0;    m_swk[m] = -1;
   endtask

   task automatic model_step(input int m, input int nf, input bit sw);
      int         w;
      int         i;
      int         a;
      logic [3:0] elig;
      if (m_swk[m] >= 0 && m_swk[m] < nf-1) begin
         m_swk[m]  = m_swk[m] + 1;
         e_gnt[m]  = 4'h0;
         e_en[m]   = 8'(1 << m_swk[m]);
         e_d[m]    = 1'b0;
         e_busy[m] = 1'b1;
      end else if (m_swk[m] < 0 && sw) begin
         m_swk[m]  = 0;
         e_gnt[m]  = 4'h0;
         e_en[m]   = 8'h01;
         e_d[m]    = 1'b0;
         e_busy[m] = 1'b1;
      end else begin
         m_swk[m]  = -1;
         e_busy[m] = 1'b0;
         elig      = req & ~e_gnt[m];
         w         = -1;
         for (int k = 0; k < 4; k++) begin
            i = (m_ptr[m] + k) % 4;
            if (w < 0 && elig[i]) w = i;
         end
         if (w < 0) begin
            e_gnt[m] = 4'h0;
            e_en[m]  = 8'h00;
         end else begin
            a        = int'(req_addr[w*3 +: 3]);
            e_gnt[m] = 4'(1 << w);
            e_d[m]   = req_val[w];
            e_en[m]  = (a < nf) ? 8'(1 << a) : 8'h00;
            m_ptr[m] = (w + 1) % 4;
         end
      end
   endtask

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, 8, sweep_start);
         model_step(1, 6, 1'b0);
      end
   end

   // Compare process: outputs are registered, so every negative edge is
   // a meaningful sample point.
   always @(negedge clk) begin
      check("cycle_dut8", {18'h0, gnt8, ff_en8, ff_d8, busy8},
                          {18'h0, e_gnt[0], e_en[0], e_d[0], e_busy[0]});
      check("cycle_dut6", {18'h0, gnt6, 2'b00, ff_en6, ff_d6, busy6},
                          {18'h0, e_gnt[1], e_en[1], e_d[1], e_busy[1]});
   end

   // ----------------------------------------------------------------------
   // Directed stimulus table (each row applied for three cycles)
   // ----------------------------------------------------------------------
   logic [3:0]  pat_req  [8] = '{4'b1010, 4'b0110, 4'b1111, 4'b1001,
                                 4'b0001, 4'b1100, 4'b0000, 4'b1111};
   logic [11:0] pat_addr [8] = '{12'o7654, 12'o0123, 12'o5555, 12'o7070,
                                 12'o0006, 12'o3216, 12'o0000, 12'o6677};
   logic [3:0]  pat_val  [8] = '{4'b1100, 4'b0011, 4'b1010, 4'b0101,
                                 4'b0001, 4'b1111, 4'b0000, 4'b1001};

   // ----------------------------------------------------------------------
   // Main sequence
   // ----------------------------------------------------------------------
   initial begin
      clr         = 1'b0;
      req         = 4'b1111;
      req_addr    = 12'o7530;     // a3=7 a2=5 a1=3 a0=0
      req_val     = 4'b1001;
      sweep_start = 1'b0;

      // Reset held with all requesting: everything quiet.
      repeat (2) @(negedge clk);
      check("rst_gnt",  {28'h0, gnt8},  32'h0);
      check("rst_en",   {24'h0, ff_en8}, 32'h0);
      check("rst_d",    {31'h0, ff_d8},  32'h0);
      check("rst_busy", {31'h0, busy8},  32'h0);

      // Release: round-robin 0,1,2,3,0 on consecutive cycles.
      clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rr_gnt", {28'h0, gnt8}, 32'(1 << (i % 4)));
         if (i == 2) check("rr_en_addr5", {24'h0, ff_en8}, 32'h20);
         if (i == 3) begin
            check("oor_gnt6", {28'h0, gnt6}, 32'h8);
            check("oor_en6",  {26'h0, ff_en6}, 32'h0);
            check("inr_en8",  {24'h0, ff_en8}, 32'h80);
         end
      end
      req = 4'b0000;

      // No request: no grant, ff_d holds the last written value (val0=1).
      @(negedge clk);
      check("idle_gnt",  {28'h0, gnt8}, 32'h0);
      check("idle_hold", {31'h0, ff_d8}, 32'h1);
      check("q5_before", {31'h0, q8[5]}, 32'h0);

      // Single request: requester 2 writes 1 to flag 5.
      req_val = 4'b0100;
      req     = 4'b0100;
      @(negedge clk);
      check("single_gnt", {28'h0, gnt8},   32'h4);
      check("single_en",  {24'h0, ff_en8}, 32'h20);
      check("single_d",   {31'h0, ff_d8},  32'h1);
      req = 4'b0000;
      @(negedge clk);
      check("single_q5",  {31'h0, q8[5]},  32'h1);

      // Same requester held: granted every second cycle only.
      req = 4'b0010;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("repeat_gnt", {28'h0, gnt8}, (j % 2 == 0) ? 32'h2 : 32'h0);
      end
      req = 4'b0000;
      @(negedge clk);

`ifdef FLAG_ARB_SWEEP_EN
      // Sweep with a simultaneous request: 8 walking enables, then grant.
      req_val     = 4'b0001;
      sweep_start = 1'b1;
      req         = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) sweep_start = 1'b0;
         check("sweep_en",   {24'h0, ff_en8}, 32'(1 << k));
         check("sweep_busy", {31'h0, busy8},  32'h1);
         check("sweep_gnt",  {28'h0, gnt8},   32'h0);
         check("sweep_d",    {31'h0, ff_d8},  32'h0);
      end
      @(negedge clk);
      check("post_sweep_gnt",  {28'h0, gnt8},   32'h1);
      check("post_sweep_busy", {31'h0, busy8},  32'h0);
      check("post_sweep_en",   {24'h0, ff_en8}, 32'h1);
      req = 4'b0000;
      @(negedge clk);

      // Reset during sweep cycle 3 aborts immediately.
      sweep_start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) sweep_start = 1'b0;
      end
      check("abort_pre_en", {24'h0, ff_en8}, 32'h08);
      #2 clr = 1'b0;
      #1;
      check("abort_out",   {18'h0, gnt8, ff_en8, ff_d8, busy8}, 32'h0);
      check("abort_state", {31'h0, dbg8}, 32'h0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
`endif

      // Directed pattern table, checked by the model every cycle.
      for (int p = 0; p < 8; p++) begin
         req      = pat_req[p];
         req_addr = pat_addr[p];
         req_val  = pat_val[p];
         repeat (3) @(negedge clk);
      end
      req = 4'b0000;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
